deserializador_fifo: RTL and testbench

//   Parametrised serial-to-parallel converter with output word FIFO. Assembles WIDTH-bit words from
//   a 1-bit stream qualified by write_in, selectable MSB/LSB-first, and queues up to DEPTH completed

---
 rtl/deserializador_fifo.sv | 117 +++++++++++
 tb/tb_deserializador_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/deserializador_fifo.sv
// deserializador_fifo: serial-to-parallel word assembler feeding a small word FIFO.
// Bits qualified by write_in are shifted in (MSB- or LSB-first). Each WIDTH-th bit
// completes a word that is queued on the same edge. Words are dropped, with a sticky
// overflow flag, only when the FIFO is full and not popped in that cycle.
module deserializador_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       ack_in,
  input  logic                       clear_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_ready,
  output logic                       status_out,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_sr;
  logic [BW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic [WIDTH-1:0] w_shift;
  logic             w_complete;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  // Next shift-register value for the incoming bit, in the configured bit order
  always_comb begin
    w_shift = r_sr;
    if (MSB_FIRST != 0) begin
      w_shift = {r_sr[WIDTH-2:0], data_in};
    end else begin
      w_shift = {data_in, r_sr[WIDTH-1:1]};
    end
  end

  // Push/pop/drop decisions; a pop in the same cycle frees the slot for a push into a full FIFO
  always_comb begin
    w_empty    = (r_count == '0);
    w_full     = (r_count == CW'(DEPTH));
    w_complete = write_in && (r_bitcnt == BW'(WIDTH-1));
    w_pop      = ack_in && !w_empty;
    w_push     = w_complete && (!w_full || w_pop);
    w_drop     = w_complete && !w_push;
  end

  // Serial assembly: shift register and bit counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sr     <= '0;
      r_bitcnt <= '0;
    end else if (clear_in) begin
      r_sr     <= '0;
      r_bitcnt <= '0;
    end else if (write_in) begin
      r_sr     <= w_shift;
      r_bitcnt <= w_complete ? '0 : r_bitcnt + 1'b1;
    end
  end

  // Word storage; contents are only observed through the count-qualified head mux
  always_ff @(posedge clock) begin
    if (reset && !clear_in && w_push) begin
      r_mem[r_wptr] <= w_shift;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clear_in) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Output decodes from registered state
  always_comb begin
    data_out   = w_empty ? '0 : r_mem[r_rptr];
    data_ready = !w_empty;
    status_out = w_full;
    fifo_count = r_count;
    overflow   = r_overflow;
  end

endmodule

// File: tb/tb_deserializador_fifo.sv
// tb_deserializador_fifo: directed checks of the deserialiser FIFO, with an MSB-first
// and an LSB-first instance driven by the same stream.
module tb_deserializador_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b0;
  logic       write_in = 1'b0;
  logic       ack_in = 1'b0;
  logic       clear_in = 1'b0;

  logic [7:0] m_data, l_data;
  logic       m_ready, l_ready, m_status, l_status, m_ovf, l_ovf;
  logic [2:0] m_count, l_count;

  int checks = 0;
  int errors = 0;

  deserializador_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) u_msb (
    .clock(clock), .reset(reset), .data_in(data_in), .write_in(write_in),
    .ack_in(ack_in), .clear_in(clear_in), .data_out(m_data), .data_ready(m_ready),
    .status_out(m_status), .fifo_count(m_count), .overflow(m_ovf)
  );

  deserializador_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) u_lsb (
    .clock(clock), .reset(reset), .data_in(data_in), .write_in(write_in),
    .ack_in(ack_in), .clear_in(clear_in), .data_out(l_data), .data_ready(l_ready),
    .status_out(l_status), .fifo_count(l_count), .overflow(l_ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Send one 8-bit word; msb selects transmission order; ack_last raises ack_in on the final bit
  task automatic send_word(input logic [7:0] w, input logic msb, input logic ack_last);
    for (int i = 0; i < 8; i++) begin
      data_in  = msb ? w[7-i] : w[i];
      write_in = 1'b1;
      ack_in   = ack_last && (i == 7);
      tick();
    end
    write_in = 1'b0;
    ack_in   = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic pop();
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
  endtask

  task automatic do_clear();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] words[16];
  logic       model_ovf;

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_data",   m_data, 8'h00);
    chk("rst_ready",  m_ready, 1'b0);
    chk("rst_status", m_status, 1'b0);
    chk("rst_count",  m_count, 3'd0);
    chk("rst_ovf",    m_ovf, 1'b0);
    chk("rst_lcount", l_count, 3'd0);
    reset = 1'b1;
    tick();

    // T1: palindromic A5 reads back as A5 on both instances
    send_word(8'hA5, 1'b1, 1'b0);
    chk("t1_ready", m_ready, 1'b1);
    chk("t1_data",  m_data, 8'hA5);
    chk("t1_count", m_count, 3'd1);
    chk("t1_ldata", l_data, 8'hA5);
    pop();
    chk("t1_pop_count", m_count, 3'd0);
    chk("t1_pop_data",  m_data, 8'h00);

    // T2: bit order, 1E sent MSB-first and then LSB-first
    send_word(8'h1E, 1'b1, 1'b0);
    chk("t2_msb_msb", m_data, 8'h1E);
    chk("t2_msb_lsb", l_data, 8'h78);
    pop();
    send_word(8'h1E, 1'b0, 1'b0);
    chk("t2_lsb_lsb", l_data, 8'h1E);
    chk("t2_lsb_msb", m_data, 8'h78);
    pop();

    // T3: fill, overflow, ordered drain
    for (int i = 1; i <= 4; i++) send_word(8'(i), 1'b1, 1'b0);
    chk("t3_status", m_status, 1'b1);
    chk("t3_count",  m_count, 3'd4);
    chk("t3_ovf0",   m_ovf, 1'b0);
    chk("t3_lstatus", l_status, 1'b1);
    send_word(8'h05, 1'b1, 1'b0);
    chk("t3_ovf1",    m_ovf, 1'b1);
    chk("t3_count5",  m_count, 3'd4);
    chk("t3_lovf",    l_ovf, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk("t3_head", m_data, 32'(i));
      pop();
    end
    chk("t3_ready_end", m_ready, 1'b0);
    chk("t3_data_end",  m_data, 8'h00);
    chk("t3_ovf_sticky", m_ovf, 1'b1);
    do_clear();
    chk("t3_ovf_clear", m_ovf, 1'b0);

    // T4: completing bit into a full FIFO with simultaneous ack
    for (int i = 0; i < 4; i++) send_word(8'h10 + 8'(i), 1'b1, 1'b0);
    send_word(8'h14, 1'b1, 1'b1);
    chk("t4_count",  m_count, 3'd4);
    chk("t4_ovf",    m_ovf, 1'b0);
    chk("t4_status", m_status, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk("t4_head", m_data, 32'h10 + 32'(i));
      pop();
    end
    chk("t4_empty", m_count, 3'd0);

    // T5: gapped stream with random back-pressure against a reference queue
    do_clear();
    foreach (words[k]) words[k] = 8'($urandom_range(0, 255));
    model_ovf = 1'b0;
    begin
      int wi = 0;
      int bp = 0;
      for (int cyc = 0; cyc < 3000 && wi < 16; cyc++) begin
        logic w, a, p, c;
        int sz;
        w = 1'($urandom_range(0, 1));
        a = ($urandom_range(0, 3) == 0);
        data_in  = w ? words[wi][7-bp] : 1'b0;
        write_in = w;
        ack_in   = a;
        sz = q.size();
        p  = a && (sz != 0);
        c  = w && (bp == 7);
        if (p) chk("t5_head", m_data, q[0]);
        tick();
        if (p) void'(q.pop_front());
        if (c) begin
          if (sz < 4 || p) q.push_back(words[wi]);
          else model_ovf = 1'b1;
        end
        if (w) begin
          if (bp == 7) begin
            bp = 0;
            wi++;
          end else begin
            bp++;
          end
        end
        chk("t5_count", m_count, 32'(q.size()));
        chk("t5_ovf",   m_ovf, model_ovf);
      end
      write_in = 1'b0;
      ack_in   = 1'b0;
      chk("t5_sent", wi, 16);
      for (int cyc = 0; cyc < 16 && q.size() != 0; cyc++) begin
        chk("t5_drain_head", m_data, q[0]);
        pop();
        void'(q.pop_front());
      end
      chk("t5_drained", m_count, 3'd0);
      pop();
      chk("t5_ack_empty", m_count, 3'd0);
      chk("t5_ack_empty_ready", m_ready, 1'b0);
    end

    // T6: async reset mid-word with two words queued
    do_clear();
    send_word(8'h21, 1'b1, 1'b0);
    send_word(8'h22, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      data_in = 1'b1; write_in = 1'b1; tick();
    end
    write_in = 1'b0;
    chk("t6_pre_count", m_count, 3'd2);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_count", m_count, 3'd0);
    chk("t6_rst_ready", m_ready, 1'b0);
    chk("t6_rst_data",  m_data, 8'h00);
    chk("t6_rst_status", m_status, 1'b0);
    chk("t6_rst_ovf",   m_ovf, 1'b0);
    reset = 1'b1;
    tick();
    send_word(8'h5A, 1'b1, 1'b0);
    chk("t6_rst_word",  m_data, 8'h5A);
    chk("t6_rst_wcount", m_count, 3'd1);
    pop();

    // T6b: synchronous clear with the same setup; clear beats a concurrent write
    send_word(8'h21, 1'b1, 1'b0);
    send_word(8'h22, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      data_in = 1'b1; write_in = 1'b1; tick();
    end
    clear_in = 1'b1;
    ack_in   = 1'b1;
    tick();
    clear_in = 1'b0;
    ack_in   = 1'b0;
    write_in = 1'b0;
    chk("t6_clr_count", m_count, 3'd0);
    chk("t6_clr_ready", m_ready, 1'b0);
    chk("t6_clr_data",  m_data, 8'h00);
    send_word(8'h5A, 1'b1, 1'b0);
    chk("t6_clr_word",  m_data, 8'h5A);
    chk("t6_clr_wcount", m_count, 3'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
